qspi_tx_serializer: RTL and testbench
=====================================

# qspi_tx_serializer

Transmit-side consumer of the controller's TX data FIFO. Pops 32-bit words through the FIFO read port (registered read data, one-cycle latency) and serializes them MSB-first onto the QSPI IO lanes in single, dual or quad mode, generating SCLK (SPI mode 0) from a programmable divider. Sits between the TX FIFO and the QSPI pad interface; started by the command sequencer once the command/address phases are complete.

## Interface
- DATA_WIDTH, 32, FIFO word width; fixed at 32 for this block
- CNT_W, 16, width of word_count
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a transfer; ignored while busy
- word_count  in  CNT_W  words to send; latched on accepted start
- lane_mode  in  2  00 single, 01 dual, 10 quad, 11 treated as single; latched on start
- clk_div  in  8  SCLK half-period = clk_div+1 clk cycles; latched on start
- abort  in  1  synchronous abort; wins over all other activity
- fifo_rd_en  out  1  FIFO pop request
- fifo_rd_data  in  32  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- sclk  out  1  serial clock, idle low
- io_out  out  4  lane data
- io_oe  out  4  lane output enables
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- underrun  out  1  sticky; FIFO was empty when a word was needed; cleared on next accepted start

## Operation
- States: IDLE, FETCH, WAIT_DATA, SHIFT, DONE.
- IDLE: start with word_count≠0 → latch inputs, words_left=word_count, underrun=0, → FETCH. start with word_count=0 → DONE (no SCLK, no pop).
- FETCH: fifo_rd_en = !fifo_empty (combinational, only in FETCH). If !fifo_empty → WAIT_DATA; else stay, set underrun=1, sclk held low.
- WAIT_DATA: at cycle end load shreg←fifo_rd_data, beats_left = 32/16/8 (single/dual/quad), ph=0, → SHIFT.
- SHIFT: ph=0 is low phase, ph=1 high phase; each phase lasts clk_div+1 cycles (half counter hc 0..clk_div).
  - End of low phase: sclk←1, ph←1.
  - End of high phase: sclk←0; if beats_left==1: words_left−1; → DONE if words_left was 1, else → FETCH. Otherwise shreg shifts left by 1/2/4, beats_left−1, ph←0.
- DONE: done=1 for one cycle → IDLE.
- Lane mapping (MSB first): single io_out[0]=shreg[31], io_oe=0001; dual io_out[1:0]=shreg[31:30], io_oe=0011; quad io_out[3:0]=shreg[31:28], io_oe=1111. Undriven lanes io_out=0.
- io_oe asserted in FETCH, WAIT_DATA, SHIFT; 0 in IDLE and DONE. io_out holds shreg MSBs while io_oe asserted, 0 otherwise.
- busy=1 in all states except IDLE.
- Data changes only while sclk low (mode 0: receiver samples on rising edge); the shift happens on the same edge where sclk falls.
- abort: next edge → IDLE, sclk=0, io_oe=0, no done pulse, no pop issued that cycle; underrun keeps its value.
- Underrun stall freezes SCLK low; transfer resumes unchanged when the FIFO becomes non-empty; no data lost.

## Timing
- Reset: sclk=0, io_out=0, io_oe=0, fifo_rd_en=0, busy=0, done=0, underrun=0, state IDLE.
- Per word, FIFO non-empty: 1 FETCH + 1 WAIT_DATA + 2·(clk_div+1)·beats SHIFT cycles.
- Start accepted at edge E0 → FETCH during cycle 1; first sclk rise at E(2+clk_div+1).
- Single word, quad, clk_div=0: SHIFT cycles 3–18, done high cycle 19, busy low from cycle 20.
- sclk low for ≥1 clk between words (FETCH+WAIT_DATA gap).
- Reset mid-transfer: all outputs to reset values immediately (asynchronous).

## Test plan
- Quad, clk_div=0, 1 word 0xA5C30F96 → 8 rising edges with io_out[3:0]=A,5,C,3,0,F,9,6; io_oe=1111; done at cycle 19; exactly one fifo_rd_en.
- Single, clk_div=2, 2 words 0x80000001, 0xFFFFFFFF → 64 rising edges, each sclk phase 3 cycles; io_out[0] = 1,0×30,1 then 1×32; io_oe=0001; 2 pops.
- Dual, FIFO empty at start, word 0x12345678 pushed 10 cycles later → underrun=1, sclk stays 0 during stall, then pairs 00,01,00,10,00,11,01,00,01,01,01,10,01,11,10,00; underrun stays 1 until next start.
- word_count=0 → done pulses 1 cycle after start, no sclk edges, no fifo_rd_en.
- Abort during word 2 of 4 → IDLE next edge, sclk=0, io_oe=0, no done; next start clears underrun and runs normally.
- Async rst_n low mid-SHIFT → all outputs zero immediately; start ignored while busy (no relatch of word_count).

Source files
------------

// File: rtl/qspi_tx_serializer.sv
// qspi_tx_serializer
// Pops 32-bit words from the TX FIFO (registered read data, one-cycle latency)
// and shifts them MSB-first onto 1, 2 or 4 QSPI IO lanes with a mode-0 SCLK.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, word_count   transfer request and word count (latched on accept)
//   lane_mode, clk_div  lane width select and SCLK half-period minus one
//   abort               synchronous abort, overrides everything
//   fifo_rd_en/_data/_empty  FIFO read port (fifo_rd_en is combinational)
//   sclk, io_out, io_oe QSPI pad interface
//   busy, done, underrun status
module qspi_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      word_count,
    input  logic [1:0]            lane_mode,
    input  logic [7:0]            clk_div,
    input  logic                  abort,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  sclk,
    output logic [3:0]            io_out,
    output logic [3:0]            io_oe,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int unsigned BEAT_W = 6;
    localparam int unsigned DIV_W  = 8;
    localparam logic [1:0]  MODE_DUAL = 2'b01;
    localparam logic [1:0]  MODE_QUAD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      words_left_q, words_left_d;
    logic [BEAT_W-1:0]     beats_q, beats_d;
    logic [DIV_W-1:0]      hc_q, hc_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  ph_q, ph_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic [3:0]            io_out_q, io_out_d;
    logic [3:0]            io_oe_q, io_oe_d;

    logic [BEAT_W-1:0]     beats_init_c;
    logic [DATA_WIDTH-1:0] shreg_shifted_c;
    logic                  lane_active_c;
    logic [3:0]            lane_mask_c;
    logic [3:0]            lane_data_c;

    // Beat count and shift step of the latched lane mode (11 behaves as single)
    always_comb begin
        beats_init_c    = BEAT_W'(DATA_WIDTH);
        shreg_shifted_c = shreg_q << 1;
        case (mode_q)
            MODE_DUAL: begin
                beats_init_c    = BEAT_W'(DATA_WIDTH / 2);
                shreg_shifted_c = shreg_q << 2;
            end
            MODE_QUAD: begin
                beats_init_c    = BEAT_W'(DATA_WIDTH / 4);
                shreg_shifted_c = shreg_q << 4;
            end
            default: ;
        endcase
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        beats_d      = beats_q;
        hc_d         = hc_q;
        ph_d         = ph_q;
        div_d        = div_q;
        mode_d       = mode_q;
        shreg_d      = shreg_q;
        sclk_d       = 1'b0;
        underrun_d   = underrun_q;
        fifo_rd_en   = 1'b0;
        lane_mask_c  = 4'b0001;
        lane_data_c  = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    underrun_d   = 1'b0;
                    mode_d       = lane_mode;
                    div_d        = clk_div;
                    words_left_d = word_count;
                    state_d      = (word_count != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                // Stall with SCLK low until a word is available
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                end else begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                shreg_d = fifo_rd_data;
                beats_d = beats_init_c;
                hc_d    = '0;
                ph_d    = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sclk_d = sclk_q;
                if (hc_q != div_q) begin
                    hc_d = hc_q + DIV_W'(1);
                end else begin
                    hc_d = '0;
                    if (!ph_q) begin
                        sclk_d = 1'b1;
                        ph_d   = 1'b1;
                    end else begin
                        // Falling edge: next beat is presented while SCLK is low
                        sclk_d = 1'b0;
                        ph_d   = 1'b0;
                        if (beats_q == BEAT_W'(1)) begin
                            words_left_d = words_left_q - CNT_W'(1);
                            state_d      = (words_left_q == CNT_W'(1)) ? S_DONE : S_FETCH;
                        end else begin
                            shreg_d = shreg_shifted_c;
                            beats_d = beats_q - BEAT_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            sclk_d     = 1'b0;
            fifo_rd_en = 1'b0;
            underrun_d = underrun_q;
        end

        // Lane view of the next shift register contents
        case (mode_d)
            MODE_DUAL: begin
                lane_mask_c = 4'b0011;
                lane_data_c = {2'b00, shreg_d[DATA_WIDTH-1 -: 2]};
            end
            MODE_QUAD: begin
                lane_mask_c = 4'b1111;
                lane_data_c = shreg_d[DATA_WIDTH-1 -: 4];
            end
            default: begin
                lane_mask_c = 4'b0001;
                lane_data_c = {3'b000, shreg_d[DATA_WIDTH-1]};
            end
        endcase

        lane_active_c = (state_d == S_FETCH) || (state_d == S_WAIT_DATA) || (state_d == S_SHIFT);
        io_oe_d       = lane_active_c ? lane_mask_c : 4'b0000;
        io_out_d      = lane_active_c ? lane_data_c : 4'b0000;
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            beats_q      <= '0;
            hc_q         <= '0;
            div_q        <= '0;
            ph_q         <= 1'b0;
            mode_q       <= '0;
            shreg_q      <= '0;
            sclk_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            io_out_q     <= '0;
            io_oe_q      <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            beats_q      <= beats_d;
            hc_q         <= hc_d;
            div_q        <= div_d;
            ph_q         <= ph_d;
            mode_q       <= mode_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            io_out_q     <= io_out_d;
            io_oe_q      <= io_oe_d;
        end
    end

    assign sclk     = sclk_q;
    assign io_out   = io_out_q;
    assign io_oe    = io_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Bench for qspi_tx_serializer: FIFO model, SCLK-edge monitor and a
// word-to-beat reference model derived from the lane mapping rules.
module tb_qspi_tx_serializer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] word_count;
    logic [1:0]  lane_mode;
    logic [7:0]  clk_div;
    logic        abort;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_empty;
    logic        sclk;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        busy;
    logic        done;
    logic        underrun;

    qspi_tx_serializer #(.DATA_WIDTH(32), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .word_count   (word_count),
        .lane_mode    (lane_mode),
        .clk_div      (clk_div),
        .abort        (abort),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .sclk         (sclk),
        .io_out       (io_out),
        .io_oe        (io_oe),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO model
    logic [31:0] fifo_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Monitor state
    logic [3:0]  rise_io[$];
    logic [3:0]  rise_oe[$];
    int          hi_len[$];
    int          hi_cur;
    int          unstable;
    int          rd_en_cnt;
    int          done_cnt;
    int          done_at;
    int          cyc;
    logic        prev_sclk = 1'b0;

    // Reference model
    logic [31:0] exp_words[$];
    logic [3:0]  exp_beats[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr++;
    endtask

    // One clock: FIFO pop on the edge, then sample outputs 1ns later
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = fifo_rd_en && !fifo_empty;
        if (fifo_rd_en) rd_en_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            fifo_rd_data = fifo_mem[rd_ptr % 1024];
            rd_ptr++;
        end
        if (sclk && !prev_sclk) begin
            rise_io.push_back(io_out);
            rise_oe.push_back(io_oe);
            hi_cur = 1;
        end else if (sclk) begin
            hi_cur++;
            if (rise_io.size() > 0 && io_out !== rise_io[$]) unstable++;
        end else if (prev_sclk) begin
            hi_len.push_back(hi_cur);
        end
        if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = cyc;
        end
        prev_sclk = sclk;
    endtask

    function automatic int bits_of(input logic [1:0] m);
        return (m == 2'b10) ? 4 : (m == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [3:0] oe_of(input logic [1:0] m);
        return (m == 2'b10) ? 4'b1111 : (m == 2'b01) ? 4'b0011 : 4'b0001;
    endfunction

    function automatic int xfer_cycles(input int n, input logic [1:0] m, input int d);
        return n * (2 + 2 * (d + 1) * (32 / bits_of(m))) + 1;
    endfunction

    // Expected lane values at each rising SCLK edge, MSB-first
    task automatic build_expect(input logic [1:0] m);
        int b;
        logic [31:0] v;
        b = bits_of(m);
        exp_beats.delete();
        foreach (exp_words[i]) begin
            for (int k = 0; k < 32 / b; k++) begin
                v = (exp_words[i] >> (32 - b * (k + 1))) & ((32'd1 << b) - 32'd1);
                exp_beats.push_back(v[3:0]);
            end
        end
    endtask

    task automatic do_start(input int n, input logic [1:0] m, input int d);
        rise_io.delete();
        rise_oe.delete();
        hi_len.delete();
        unstable  = 0;
        rd_en_cnt = 0;
        done_cnt  = 0;
        done_at   = 0;
        cyc       = 0;
        prev_sclk = sclk;
        word_count = 16'(n);
        lane_mode  = m;
        clk_div    = 8'(d);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        while (done_cnt == 0 && cyc < budget) tick();
        if (done_cnt == 0) chk("timeout_done", 0, 1);
    endtask

    task automatic check_xfer(input string tag, input logic [1:0] m, input int d, input int exp_done);
        int derr, oerr, herr, n;
        build_expect(m);
        chk({tag, "_rises"}, rise_io.size(), exp_beats.size());
        n = (rise_io.size() < exp_beats.size()) ? rise_io.size() : exp_beats.size();
        derr = 0;
        oerr = 0;
        herr = 0;
        for (int i = 0; i < n; i++) begin
            if (rise_io[i] !== exp_beats[i]) derr++;
            if (rise_oe[i] !== oe_of(m)) oerr++;
        end
        foreach (hi_len[i]) if (hi_len[i] != d + 1) herr++;
        chk({tag, "_data_err"}, derr, 0);
        chk({tag, "_oe_err"}, oerr, 0);
        chk({tag, "_hi_len_err"}, herr, 0);
        chk({tag, "_unstable"}, unstable, 0);
        chk({tag, "_pops"}, rd_en_cnt, exp_words.size());
        chk({tag, "_done_cnt"}, done_cnt, 1);
        if (exp_done != 0) chk({tag, "_done_at"}, done_at, exp_done);
        tick();
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_oe_after"}, io_oe, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_io_out"}, io_out, 0);
        chk({tag, "_io_oe"}, io_oe, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        logic [1:0]  m;
        int          d;
        int          n;
        int          derr;

        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        word_count   = '0;
        lane_mode    = '0;
        clk_div      = '0;
        fifo_rd_data = '0;

        // Reset values
        #12;
        check_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("after_reset");

        // Quad, clk_div=0, one word
        exp_words = '{32'hA5C30F96};
        push(32'hA5C30F96);
        do_start(1, 2'b10, 0);
        run_to_done(200);
        check_xfer("quad1", 2'b10, 0, 19);

        // Single, clk_div=2, two words
        exp_words = '{32'h80000001, 32'hFFFFFFFF};
        push(32'h80000001);
        push(32'hFFFFFFFF);
        do_start(2, 2'b00, 2);
        run_to_done(1000);
        check_xfer("single2", 2'b00, 2, xfer_cycles(2, 2'b00, 2));

        // word_count = 0
        exp_words.delete();
        do_start(0, 2'b10, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("zero_done_at", done_at, 1);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_rises", rise_io.size(), 0);
        chk("zero_pops", rd_en_cnt, 0);
        chk("zero_busy", busy, 0);

        // Dual with FIFO empty at start, word arrives 10 cycles later
        exp_words = '{32'h12345678};
        do_start(1, 2'b01, 0);
        for (int i = 0; i < 9; i++) tick();
        chk("stall_underrun", underrun, 1);
        chk("stall_sclk", sclk, 0);
        chk("stall_rises", rise_io.size(), 0);
        chk("stall_pops", rd_en_cnt, 0);
        push(32'h12345678);
        run_to_done(300);
        check_xfer("stall", 2'b01, 0, 0);
        chk("stall_underrun_sticky", underrun, 1);

        // Abort during word 2 of 4 (after an underrun on word 2)
        exp_words = '{$urandom, $urandom};
        push(exp_words[0]);
        do_start(4, 2'b10, 1);
        chk("abort_start_clears_underrun", underrun, 0);
        while (underrun == 1'b0 && cyc < 200) tick();
        for (int i = 0; i < 4; i++) tick();
        chk("abort_stall_sclk", sclk, 0);
        chk("abort_stall_rises", rise_io.size(), 8);
        push(exp_words[1]);
        while (rise_io.size() < 11 && cyc < 400) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sclk", sclk, 0);
        chk("abort_io_oe", io_oe, 0);
        chk("abort_underrun_kept", underrun, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_pops", rd_en_cnt, 2);
        build_expect(2'b10);
        derr = 0;
        foreach (rise_io[i]) if (i < exp_beats.size() && rise_io[i] !== exp_beats[i]) derr++;
        chk("abort_prefix_data_err", derr, 0);
        wr_ptr = rd_ptr;

        // Normal run after abort
        exp_words = '{$urandom};
        push(exp_words[0]);
        do_start(1, 2'b10, 1);
        chk("post_abort_underrun", underrun, 0);
        run_to_done(300);
        check_xfer("post_abort", 2'b10, 1, xfer_cycles(1, 2'b10, 1));

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            m = 2'($urandom_range(0, 3));
            d = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            exp_words.delete();
            for (int i = 0; i < n; i++) begin
                exp_words.push_back($urandom);
                push(exp_words[i]);
            end
            do_start(n, m, d);
            run_to_done(3000);
            check_xfer($sformatf("rand%0d", t), m, d, xfer_cycles(n, m, d));
        end

        // Start ignored while busy
        exp_words = '{$urandom};
        push(exp_words[0]);
        push($urandom);
        do_start(1, 2'b00, 0);
        for (int i = 0; i < 20; i++) tick();
        word_count = 16'd5;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        run_to_done(300);
        check_xfer("busy_start", 2'b00, 0, xfer_cycles(1, 2'b00, 0));
        wr_ptr = rd_ptr;

        // Asynchronous reset mid-SHIFT
        push($urandom);
        push($urandom);
        do_start(2, 2'b00, 1);
        while (!(rise_io.size() >= 5 && sclk) && cyc < 500) tick();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_ptr = rd_ptr;
        tick();
        chk("post_reset_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
